// File: rtl/histogram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : histogram_pkg                                             |
// | Purpose  : Shared FSM state type and saturation limits for the       |
// |            streaming histogram accumulator.                          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package histogram_pkg;

   // CLEAR sweeps every bin to zero; RUN accepts samples and readouts.
   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // All-ones value of a w-bit counter. The result is returned in 64 bits
   // and truncated by the caller.
   function automatic logic [63:0] all_ones(input int unsigned w);
      if (w >= 64) begin
         return '1;
      end
      return (64'd1 << w) - 64'd1;
   endfunction

   // Saturation value of a per-bin counter of width cnt_w.
   function automatic logic [63:0] count_max(input int unsigned cnt_w);
      return all_ones(cnt_w);
   endfunction

   // Saturation value of the total-sample counter of width total_w.
   function automatic logic [63:0] total_max(input int unsigned total_w);
      return all_ones(total_w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/histogram_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : histogram_ram                                             |
// | Purpose  : Bin-count storage, one write port and two synchronous     |
// |            read-first read ports (A: update, B: readout).            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module histogram_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write plus two registered reads; reads see the pre-write contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
   end

endmodule
`default_nettype wire

// File: rtl/histogram_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : histogram_accumulator                                     |
// | Purpose  : Streaming histogram: per-bin saturating counters updated  |
// |            by a 2-stage read-modify-write with forwarding, a         |
// |            latency-1 readout port, total counter, sticky saturation  |
// |            flag and a clear sweep.                                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module histogram_accumulator
   import histogram_pkg::*;
#(
   parameter int BIN_W   = 10,
   parameter int CNT_W   = 32,
   parameter int TOTAL_W = 40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_req,
   input  logic               s_valid,
   input  logic [BIN_W-1:0]   s_bin,
   output logic               s_ready,
   input  logic               rd_req,
   input  logic [BIN_W-1:0]   rd_bin,
   output logic               rd_valid,
   output logic [CNT_W-1:0]   rd_data,
   output logic [TOTAL_W-1:0] total,
   output logic               sat_flag,
   output logic               busy
);

   localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(count_max(CNT_W));
   localparam logic [TOTAL_W-1:0] TOTAL_MAX = TOTAL_W'(total_max(TOTAL_W));

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   sweep_q, sweep_d;

   // Stage-1 sample and a copy of the last RAM write for forwarding.
   logic               v1_q;
   logic [BIN_W-1:0]   bin1_q;
   logic               wr_v_q;
   logic [BIN_W-1:0]   wr_bin_q;
   logic [CNT_W-1:0]   wr_data_q;

   logic [TOTAL_W-1:0] total_q;
   logic               sat_q;
   logic               rd_valid_q;

   logic               running;
   logic               kill;
   logic               accept;
   logic               fwd_hit;
   logic [CNT_W-1:0]   old_cnt;
   logic [CNT_W-1:0]   inc_cnt;
   logic               we;
   logic [BIN_W-1:0]   waddr;
   logic [CNT_W-1:0]   wdata;
   logic [CNT_W-1:0]   ram_a;
   logic [CNT_W-1:0]   ram_b;

   assign running  = (state_q == RUN);
   assign kill     = running && clear_req;
   assign s_ready  = running;
   assign busy     = !running;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_valid_q ? ram_b : '0;
   assign total    = total_q;
   assign sat_flag = sat_q;

   // State register: reset always lands in CLEAR at sweep address 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   // Next state: sweep every bin once, then run until a clear request.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      case (state_q)
         CLEAR: begin
            sweep_d = sweep_q + BIN_W'(1);
            if (sweep_q == '1) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (clear_req) begin
               state_d = CLEAR;
               sweep_d = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            sweep_d = '0;
         end
      endcase
   end

   // Update datapath: forward the previous write when the RAM read is stale,
   // and steer the write port between the sweep and the update pipeline.
   always_comb begin
      accept  = s_valid && s_ready && !clear_req;
      fwd_hit = wr_v_q && (wr_bin_q == bin1_q);
      old_cnt = fwd_hit ? wr_data_q : ram_a;
      inc_cnt = (old_cnt == CNT_MAX) ? old_cnt : old_cnt + CNT_W'(1);
      if (running) begin
         we    = v1_q && !clear_req;
         waddr = bin1_q;
         wdata = inc_cnt;
      end else begin
         we    = 1'b1;
         waddr = sweep_q;
         wdata = '0;
      end
   end

   // Pipeline, forwarding copy, readout valid, total and sticky flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q       <= 1'b0;
         bin1_q     <= '0;
         wr_v_q     <= 1'b0;
         wr_bin_q   <= '0;
         wr_data_q  <= '0;
         rd_valid_q <= 1'b0;
         total_q    <= '0;
         sat_q      <= 1'b0;
      end else begin
         v1_q       <= accept;
         bin1_q     <= s_bin;
         wr_v_q     <= we;
         wr_bin_q   <= waddr;
         wr_data_q  <= wdata;
         rd_valid_q <= rd_req && running;
         if (kill) begin
            total_q <= '0;
            sat_q   <= 1'b0;
         end else begin
            if (accept && (total_q != TOTAL_MAX)) begin
               total_q <= total_q + TOTAL_W'(1);
            end
            if (running && we && (wdata == CNT_MAX)) begin
               sat_q <= 1'b1;
            end
         end
      end
   end

   histogram_ram #(
      .ADDR_W (BIN_W),
      .DATA_W (CNT_W)
   ) u_ram (
      .clk     (clk),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr_a (s_bin),
      .rdata_a (ram_a),
      .raddr_b (rd_bin),
      .rdata_b (ram_b)
   );

endmodule
`default_nettype wire

// File: doc/histogram_accumulator.md
# histogram_accumulator

Parametrised streaming histogram for the RRI statistics path: each accepted sample carries a bin index, and the block increments that bin's saturating counter in on-chip RAM. It adds a valid/ready input handshake, a pipelined read-modify-write with hazard forwarding, a separate latency-1 readout port, a total-sample counter, a sticky saturation flag and a hardware clear sweep. The RRI front end feeds it bin indices; software or the downstream analysis stage drains it through the readout port.

## Interface
- BIN_W, 10, bin index width; NUM_BINS = 2**BIN_W
- CNT_W, 32, per-bin counter width
- TOTAL_W, 40, total-sample counter width
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clear_req  in  1  single-cycle request to zero all bins, total and sat_flag
- s_valid  in  1  sample valid
- s_bin  in  BIN_W  sample bin index
- s_ready  out  1  block can accept a sample this cycle
- rd_req  in  1  readout request
- rd_bin  in  BIN_W  readout bin index
- rd_valid  out  1  rd_data valid
- rd_data  out  CNT_W  count of rd_bin
- total  out  TOTAL_W  accepted samples since last clear, saturating
- sat_flag  out  1  sticky: some bin reached 2**CNT_W-1
- busy  out  1  clear sweep in progress

## Operation
- FSM states: CLEAR, RUN. rst forces CLEAR with sweep address 0. This makes reset always followed by a full sweep.
- CLEAR writes 0 to one bin per cycle, address 0 to NUM_BINS-1, then moves to RUN. During CLEAR: busy=1, s_ready=0, rd_req is ignored (rd_valid stays 0), and clear_req is ignored.
- RUN: s_ready=1, busy=0. A sample is accepted when s_valid && s_ready.
- clear_req high in RUN: s_ready is still 1 that cycle, but any sample accepted that cycle and any update in flight are killed (write suppressed). Next cycle the FSM enters CLEAR. total and sat_flag go to 0 on that same edge.
- Update pipeline, stage 0 (cycle N): accept the sample and present s_bin to the RAM read port A.
- Update pipeline, stage 1 (cycle N+1): old count plus 1, saturating at 2**CNT_W-1, written to the RAM at the end of N+1.
- Forwarding: if the stage-1 bin equals the bin written on the previous edge, stage 1 uses the registered write data instead of the RAM read data. Back-to-back hits on one bin must count exactly.
- sat_flag sets on the edge where any bin's write value equals 2**CNT_W-1. It clears only on rst or clear_req.
- total increments per accepted, non-killed sample and saturates at 2**TOTAL_W-1.
- Readout uses RAM read port B. rd_req in RUN at cycle M gives rd_valid=1 and rd_data=count(rd_bin) at M+1. There is no backpressure, and a new request is allowed every cycle.

## Timing
- Reset values: s_ready=0, busy=1, rd_valid=0, rd_data=0, total=0, sat_flag=0.
- After rst deasserts, busy stays 1 for exactly NUM_BINS cycles. s_ready rises on the next cycle.
- Update latency: a sample accepted at N is reflected in rd_data for any rd_req at M >= N+2. total reflects it from N+1.
- RAM is read-first on a same-address read/write in one cycle. Port B needs no forwarding.
- Readout concurrent with updates to the same bin returns the pre- or post-update value per the M >= N+2 rule only.
- Saturated bins stay at max; further hits still increment total.

## Structure
- Shared package histogram_pkg: state enum (CLEAR, RUN), and the max-count and max-total constants as functions of CNT_W and TOTAL_W.
- Sub-module histogram_ram: NUM_BINS x CNT_W, one write port and two synchronous read-first read ports (A for update, B for readout), no reset on contents.
- Top level holds the FSM, sweep counter, update pipeline with forwarding register, total and sat_flag.

## Test plan
- Reset, BIN_W=10: busy=1 for exactly 1024 cycles and s_ready=0 throughout. Then reading all bins returns 0 and total=0.
- 5 back-to-back samples to bin 7: rd bin 7 = 5 and total=5, with the read at least 2 cycles after the last sample.
- Interleaved 7,8,7,8,7 then 3 more 8s: bin 7=3, bin 8=5, total=8.
- CNT_W=4, 20 hits on bin 2: bin 2=15, sat_flag=1 from the 15th hit, total=20.
- clear_req during a burst to bin 9: no update accepted in the clear_req cycle or in flight lands. After 1024 busy cycles, bin 9=0, total=0, sat_flag=0.
- rd_req during CLEAR: rd_valid stays 0. rd_req in RUN at cycle M: rd_valid=1 at exactly M+1 with the correct count.
